// File: rtl/compound_rr_accumulator.sv
// Multi-channel compound-message accumulator: round-robin arbitration over NUM_CH
// blocking input channels, one accumulator per channel, one shared blocking result port.
module compound_rr_accumulator #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        b_in_mode,
    input  logic [NUM_CH*DATA_W-1:0] b_in_x,
    input  logic [NUM_CH-1:0]        b_in_y,
    input  logic [NUM_CH-1:0]        b_in_sync,
    output logic [NUM_CH-1:0]        b_in_notify,
    output logic [DATA_W-1:0]        m_out,
    output logic                     m_out_notify,
    input  logic                     m_out_sync
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [PTR_W:0]   NUM_CH_W = (PTR_W+1)'(NUM_CH);
    localparam logic [PTR_W-1:0] LAST_CH  = PTR_W'(NUM_CH - 1);

    typedef enum logic {SECTION_A, SECTION_B} state_t;

    state_t            state, next_state;
    logic [PTR_W-1:0]  rr_ptr, grant_idx, ptr_next;
    logic [PTR_W:0]    cand;
    logic              grant_valid, grant_mode, grant_y;
    logic [DATA_W-1:0] grant_x;
    logic [DATA_W-1:0] acc [NUM_CH];

    // Rotating priority search starting at rr_ptr; b_in_notify is the one-hot grant.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        b_in_notify = '0;
        next_state  = state;
        if (state == SECTION_A) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cand = {1'b0, rr_ptr} + (PTR_W+1)'(i);
                if (cand >= NUM_CH_W) begin
                    cand = cand - NUM_CH_W;
                end
                if (!grant_valid && b_in_sync[cand[PTR_W-1:0]]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand[PTR_W-1:0];
                end
            end
            b_in_notify[grant_idx] = grant_valid;
            if (grant_valid && !b_in_mode[grant_idx]) begin
                next_state = SECTION_B;
            end
        end else if (m_out_sync) begin
            next_state = SECTION_A;
        end
    end

    always_comb begin
        grant_x    = '0;
        grant_mode = 1'b0;
        grant_y    = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant_idx == PTR_W'(c)) begin
                grant_x    = b_in_x[c*DATA_W +: DATA_W];
                grant_mode = b_in_mode[c];
                grant_y    = b_in_y[c];
            end
        end
        ptr_next = (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= SECTION_A;
            rr_ptr       <= '0;
            m_out        <= '0;
            m_out_notify <= 1'b0;
            // NOTE: the accumulator array is reset explicitly: a never-written channel must read 0.
            for (int c = 0; c < NUM_CH; c++) begin
                acc[c] <= '0;
            end
        end else begin
            state <= next_state;
            if (grant_valid) begin
                rr_ptr <= ptr_next;
                if (grant_mode) begin
                    acc[grant_idx] <= grant_y ? acc[grant_idx] + grant_x : grant_x;
                end else begin
                    m_out        <= acc[grant_idx];
                    m_out_notify <= 1'b1;
                    if (grant_y) begin
                        acc[grant_idx] <= '0;
                    end
                end
            end else if (state == SECTION_B && m_out_sync) begin
                m_out_notify <= 1'b0;
            end
        end
    end

endmodule
